boot_loader_ctrl: RTL and testbench

Serial boot sequencer for the J1 CPU's shared program/data memory. Holds the CPU in reset, accepts a framed byte stream (typically from a UART receiver), assembles little-endian words, and writes them into the memory through the code-side write port. After verifying the checksum it releases the CPU to run the freshly loaded image.

---
 rtl/boot_loader_pkg.sv | 22 ++
 rtl/boot_word_asm.sv | 54 +++++
 rtl/boot_loader_ctrl.sv | 151 +++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared constants and types for the serial boot loader.
// Holds the frame magic, the count width and the loader state type.
package boot_loader_pkg;

   localparam logic [7:0] BOOT_MAGIC = 8'hA5;
   localparam int         CNT_W      = 16;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      RUN,
      ERR
   } state_t;

   function automatic logic is_magic(input logic [7:0] b);
      return b == BOOT_MAGIC;
   endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Boot loader word assembler: byte shifter, byte index and XOR checksum.
// Bytes arrive LSB first; clr restarts all three at frame start.
module boot_word_asm
   import boot_loader_pkg::*;
#(
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              shift,
   input  logic [7:0]        din,
   output logic [DWIDTH-1:0] word_nxt,
   output logic              last,
   output logic [7:0]        csum
);

   localparam int BPW = DWIDTH / 8;
   localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [DWIDTH-1:0] word_q;
   logic [IW-1:0]     idx_q;
   logic [7:0]        csum_q;

   // New byte enters at the top so the first byte ends up in the LSBs.
   generate
      if (BPW == 1) begin : g_one
         assign word_nxt = din;
      end else begin : g_many
         assign word_nxt = {din, word_q[DWIDTH-1:8]};
      end
   endgenerate

   assign last = (idx_q == IW'(BPW - 1));
   assign csum = csum_q;

   // Shift register, byte index and running checksum.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q <= '0;
         idx_q  <= '0;
         csum_q <= '0;
      end else if (clr) begin
         word_q <= '0;
         idx_q  <= '0;
         csum_q <= '0;
      end else if (shift) begin
         word_q <= word_nxt;
         idx_q  <= last ? '0 : idx_q + 1'b1;
         csum_q <= csum_q ^ din;
      end
   end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Serial boot sequencer: loads a framed image and releases the CPU.
// BOOT_RELOAD_EN lets a magic byte in RUN restart loading.
module boot_loader_ctrl
   import boot_loader_pkg::*;
#(
   parameter int LOG2ABITS = 13,
   parameter int DWIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 cpu_reset,
   output logic                 mem_wr,
   output logic [LOG2ABITS-1:0] mem_addr,
   output logic [DWIDTH-1:0]    mem_dout,
   output logic                 busy,
   output logic                 err
);

   state_t               state_q;
   state_t               state_d;
   logic [7:0]           cnt_lo_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     n_in;
   logic [LOG2ABITS-1:0] addr_q;
   logic                 accept;
   logic                 magic;
   logic                 clr;
   logic                 shift;
   logic                 wr_d;
   logic                 last;
   logic                 last_word;
   logic                 too_big;
   logic [DWIDTH-1:0]    word_nxt;
   logic [7:0]           csum;

   boot_word_asm #(
      .DWIDTH (DWIDTH)
   ) u_asm (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .shift    (shift),
      .din      (rx_data),
      .word_nxt (word_nxt),
      .last     (last),
      .csum     (csum)
   );

   // The only stall is the write cycle, so ready is the inverse of the strobe.
   assign rx_ready  = ~mem_wr;
   assign accept    = rx_valid & rx_ready;
   assign magic     = is_magic(rx_data);
   assign n_in      = {rx_data, cnt_lo_q};
   assign too_big   = 32'(n_in) > (32'd1 << LOG2ABITS);
   assign last_word = 32'(addr_q) == (32'(cnt_q) - 32'd1);

   assign cpu_reset = (state_q != RUN);
   assign err       = (state_q == ERR);
   assign busy      = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and per-byte control.
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      shift   = 1'b0;
      wr_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && magic) begin
               state_d = LEN0;
               clr     = 1'b1;
            end
         end
         LEN0: begin
            if (accept) state_d = LEN1;
         end
         LEN1: begin
            if (accept) begin
               if (n_in == '0)   state_d = CSUM;
               else if (too_big) state_d = ERR;
               else              state_d = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               shift = 1'b1;
               if (last) begin
                  wr_d = 1'b1;
                  if (last_word) state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (accept) state_d = (rx_data == csum) ? RUN : ERR;
         end
         RUN: begin
`ifdef BOOT_RELOAD_EN
            if (accept && magic) begin
               state_d = LEN0;
               clr     = 1'b1;
            end
`else
            state_d = RUN;
`endif
         end
         ERR: begin
            if (accept && magic) begin
               state_d = LEN0;
               clr     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Count capture, address counter and registered write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_lo_q <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_dout <= '0;
      end else begin
         mem_wr <= wr_d;
         if (state_q == LEN0 && accept) cnt_lo_q <= rx_data;
         if (state_q == LEN1 && accept) cnt_q    <= n_in;
         if (clr) begin
            addr_q <= '0;
         end else if (wr_d) begin
            addr_q <= addr_q + 1'b1;
         end
         if (wr_d) begin
            mem_addr <= addr_q;
            mem_dout <= word_nxt;
         end
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl with hand-computed frames.
// Build with BOOT_RELOAD_EN to cover the run-time reload path.
module tb_boot_loader_ctrl;

   localparam int AW = 13;
   localparam int DW = 16;

   logic          clk;
   logic          reset;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          cpu_reset;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic          busy;
   logic          err;

   int n_chk;
   int n_fail;
   logic prev_wr;
   logic [31:0] wa[$];
   logic [31:0] wd[$];

   boot_loader_ctrl #(
      .LOG2ABITS (AW),
      .DWIDTH    (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .cpu_reset (cpu_reset),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write monitor: logs every strobe and checks pulse width / stall.
   always @(negedge clk) begin
      if (!reset && mem_wr) begin
         wa.push_back(32'(mem_addr));
         wd.push_back(32'(mem_dout));
         chk("wr_rdy", 32'(rx_ready), 0);
         chk("wr_pulse", 32'(prev_wr), 0);
      end
      prev_wr = mem_wr;
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("rx_tmo", 32'(rx_ready), 1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      wa.delete();
      wd.delete();
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_cpu"},  32'(cpu_reset), 1);
      chk({tag, "_rdy"},  32'(rx_ready), 1);
      chk({tag, "_wr"},   32'(mem_wr), 0);
      chk({tag, "_addr"}, 32'(mem_addr), 0);
      chk({tag, "_dout"}, 32'(mem_dout), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_err"},  32'(err), 0);
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      prev_wr  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      do_reset();
      chk_rst("rst");

      // Good two-word frame; XOR 34^12^78^56 = 08.
      send(8'hA5);
      chk("len0_busy", 32'(busy), 1);
      send(8'h02); send(8'h00);
      send(8'h34); send(8'h12); send(8'h78); send(8'h56);
      chk("pre_cpu", 32'(cpu_reset), 1);
      send(8'h08);
      chk("go_cpu", 32'(cpu_reset), 0);
      chk("go_err", 32'(err), 0);
      chk("go_busy", 32'(busy), 0);
      chk("go_nwr", wa.size(), 2);
      if (wa.size() == 2) begin
         chk("w0_a", wa[0], 0); chk("w0_d", wd[0], 32'h1234);
         chk("w1_a", wa[1], 1); chk("w1_d", wd[1], 32'h5678);
      end
      send(8'h11);
      chk("run_rdy", 32'(rx_ready), 1);

      // Bad checksum, then recover with a good frame.
      do_reset();
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h34); send(8'h12); send(8'h78); send(8'h56);
      send(8'h45);
      chk("bad_err", 32'(err), 1);
      chk("bad_cpu", 32'(cpu_reset), 1);
      send(8'h00);
      chk("bad_hold", 32'(err), 1);
      send(8'hA5);
      chk("rec_err", 32'(err), 0);
      chk("rec_busy", 32'(busy), 1);
      send(8'h02); send(8'h00);
      send(8'h34); send(8'h12); send(8'h78); send(8'h56);
      send(8'h08);
      chk("rec_cpu", 32'(cpu_reset), 0);
      chk("rec_nwr", wa.size(), 4);

      // Garbage then empty frame.
      do_reset();
      send(8'h00); send(8'hFF); send(8'h5A);
      chk("gar_busy", 32'(busy), 0);
      chk("gar_cpu", 32'(cpu_reset), 1);
      send(8'hA5); send(8'h00); send(8'h00);
      chk("zero_csum", 32'(busy), 1);
      send(8'h00);
      chk("zero_cpu", 32'(cpu_reset), 0);
      chk("zero_nwr", wa.size(), 0);

      // Count one above capacity.
      do_reset();
      send(8'hA5); send(8'h01); send(8'h20);
      chk("big_err", 32'(err), 1);
      chk("big_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      chk("big_nwr", wa.size(), 0);

      // Count exactly at capacity is accepted.
      do_reset();
      send(8'hA5); send(8'h00); send(8'h20);
      chk("max_busy", 32'(busy), 1);
      chk("max_err", 32'(err), 0);

      // Asynchronous reset after the third payload byte.
      do_reset();
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h34); send(8'h12); send(8'h78);
      chk("mid_nwr", wa.size(), 1);
      #2 reset = 1'b1;
      #1 chk_rst("arst");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      wa.delete();
      wd.delete();
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'hCD); send(8'hAB);
      send(8'h66);
      chk("arst_cpu", 32'(cpu_reset), 0);
      chk("arst_nwr", wa.size(), 1);
      if (wa.size() == 1) begin
         chk("arst_a", wa[0], 0);
         chk("arst_d", wd[0], 32'hABCD);
      end

      // Magic byte while running.
      wa.delete();
      wd.delete();
      send(8'hA5);
`ifdef BOOT_RELOAD_EN
      chk("rl_cpu", 32'(cpu_reset), 1);
      chk("rl_busy", 32'(busy), 1);
      send(8'h01); send(8'h00);
      send(8'hEF); send(8'hBE);
      send(8'h51);
      chk("rl_go", 32'(cpu_reset), 0);
      chk("rl_nwr", wa.size(), 1);
      if (wa.size() == 1) begin
         chk("rl_a", wa[0], 0);
         chk("rl_d", wd[0], 32'hBEEF);
      end
`else
      chk("nrl_cpu", 32'(cpu_reset), 0);
      chk("nrl_busy", 32'(busy), 0);
      chk("nrl_rdy", 32'(rx_ready), 1);
      send(8'h01);
      chk("nrl_cpu2", 32'(cpu_reset), 0);
      chk("nrl_nwr", wa.size(), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
